// File: rtl/reorder_buffer_pkg.sv
// Shared widths, null constants and pointer helper for the reorder buffer.
// Tag 0 is reserved as "no producer", so usable tags are 1..ROB_SIZE-1.
package reorder_buffer_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int REG_WIDTH    = 5;
    localparam int ROB_WIDTH    = 4;
    localparam int DEF_ROB_SIZE = 16;

    localparam logic [REG_WIDTH-1:0]  ZERO_REG  = '0;
    localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
    localparam logic                  TRUE      = 1'b1;
    localparam logic                  FALSE     = 1'b0;

    // Advance a ring pointer, skipping slot 0 on wrap.
    function automatic logic [ROB_WIDTH-1:0] rob_next(
        input logic [ROB_WIDTH-1:0] p,
        input int unsigned          size
    );
        if (32'(p) >= size - 1)
            return ROB_WIDTH'(1);
        else
            return p + ROB_WIDTH'(1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order tag allocation, CDB capture,
// in-order retirement onto the register file commit port.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = DEF_ROB_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_valid,
    input  logic [REG_WIDTH-1:0]  alloc_rd,
    output logic [ROB_WIDTH-1:0]  alloc_tag,
    output logic                  full,
    output logic                  empty,
    input  logic                  cdb_valid,
    input  logic [ROB_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_value,
    input  logic [ROB_WIDTH-1:0]  query_tag1,
    input  logic [ROB_WIDTH-1:0]  query_tag2,
    output logic                  query_ready1,
    output logic                  query_ready2,
    output logic [DATA_WIDTH-1:0] query_value1,
    output logic [DATA_WIDTH-1:0] query_value2,
    output logic [REG_WIDTH-1:0]  commit_reg,
    output logic [ROB_WIDTH-1:0]  commit_tag,
    output logic [DATA_WIDTH-1:0] commit_value
);

    logic                  r_busy  [ROB_SIZE];
    logic                  r_ready [ROB_SIZE];
    logic [REG_WIDTH-1:0]  r_rd    [ROB_SIZE];
    logic [DATA_WIDTH-1:0] r_value [ROB_SIZE];

    logic [ROB_WIDTH-1:0]  r_head;
    logic [ROB_WIDTH-1:0]  r_tail;
    logic [ROB_WIDTH-1:0]  r_count;

    logic                  w_alloc;
    logic                  w_commit;
    logic                  w_wb;
    logic                  w_clear;

    assign w_clear   = rst || flush;
    assign full      = (r_count == ROB_WIDTH'(ROB_SIZE - 1));
    assign empty     = (r_count == '0);
    assign alloc_tag = r_tail;

    assign w_alloc  = alloc_valid && !full;
    assign w_commit = r_busy[r_head] && r_ready[r_head];
    assign w_wb     = cdb_valid && (cdb_tag != ZERO_ROB) && r_busy[cdb_tag];

    // Operand lookup with same-cycle CDB bypass for both source ports.
    always_comb begin
        query_ready1 = FALSE;
        query_value1 = ZERO_DATA;
        query_ready2 = FALSE;
        query_value2 = ZERO_DATA;
        if (query_tag1 != ZERO_ROB) begin
            if (cdb_valid && cdb_tag == query_tag1) begin
                query_ready1 = TRUE;
                query_value1 = cdb_value;
            end else if (r_busy[query_tag1] && r_ready[query_tag1]) begin
                query_ready1 = TRUE;
                query_value1 = r_value[query_tag1];
            end
        end
        if (query_tag2 != ZERO_ROB) begin
            if (cdb_valid && cdb_tag == query_tag2) begin
                query_ready2 = TRUE;
                query_value2 = cdb_value;
            end else if (r_busy[query_tag2] && r_ready[query_tag2]) begin
                query_ready2 = TRUE;
                query_value2 = r_value[query_tag2];
            end
        end
    end

    // Slot state: CDB capture, allocation at tail, release at head.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_busy[i]  <= FALSE;
                r_ready[i] <= FALSE;
            end
        end else begin
            if (w_wb) begin
                r_ready[cdb_tag] <= TRUE;
                r_value[cdb_tag] <= cdb_value;
            end
            if (w_alloc) begin
                r_busy[r_tail]  <= TRUE;
                r_ready[r_tail] <= FALSE;
                r_rd[r_tail]    <= alloc_rd;
            end
            if (w_commit) begin
                r_busy[r_head]  <= FALSE;
                r_ready[r_head] <= FALSE;
            end
        end
    end

    // Ring pointers and occupancy; alloc+commit in one cycle nets zero.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= ROB_WIDTH'(1);
            r_tail  <= ROB_WIDTH'(1);
            r_count <= '0;
        end else begin
            if (w_alloc)
                r_tail <= rob_next(r_tail, ROB_SIZE);
            if (w_commit)
                r_head <= rob_next(r_head, ROB_SIZE);
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + ROB_WIDTH'(1);
                2'b01:   r_count <= r_count - ROB_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Commit port holds a retirement for exactly one cycle, else zeros.
    always_ff @(posedge clk) begin
        if (w_clear || !w_commit) begin
            commit_reg   <= ZERO_REG;
            commit_tag   <= ZERO_ROB;
            commit_value <= ZERO_DATA;
        end else begin
            commit_reg   <= r_rd[r_head];
            commit_tag   <= r_head;
            commit_value <= r_value[r_head];
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomised scoreboard bench for reorder_buffer against a
// program-order queue model of in-flight instructions.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_tag;
    logic        full;
    logic        empty;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_value1;
    logic [31:0] query_value2;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_tag    (alloc_tag),
        .full         (full),
        .empty        (empty),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_value    (cdb_value),
        .query_tag1   (query_tag1),
        .query_tag2   (query_tag2),
        .query_ready1 (query_ready1),
        .query_ready2 (query_ready2),
        .query_value1 (query_value1),
        .query_value2 (query_value2),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_value (commit_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] val;
    } ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
    } cmt_t;

    ent_t mq[$];
    cmt_t exp_q[$];
    int   m_tail;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   go = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void qexp(input logic [3:0] t, output bit r,
                                 output logic [31:0] v);
        r = 0;
        v = '0;
        if (t != 0) begin
            if (cdb_valid && cdb_tag == t) begin
                r = 1;
                v = cdb_value;
            end else begin
                foreach (mq[i])
                    if (mq[i].tag == t && mq[i].done) begin
                        r = 1;
                        v = mq[i].val;
                    end
            end
        end
    endfunction

    task automatic step(input bit av, input logic [4:0] rd,
                        input bit cv, input logic [3:0] ct,
                        input logic [31:0] cval,
                        input logic [3:0] q1, input logic [3:0] q2,
                        input bit fl, input bit rs);
        bit          er;
        logic [31:0] ev;
        bit          was_full;
        @(negedge clk);
        alloc_valid = av;
        alloc_rd    = rd;
        cdb_valid   = cv;
        cdb_tag     = ct;
        cdb_value   = cval;
        query_tag1  = q1;
        query_tag2  = q2;
        flush       = fl;
        rst         = rs;
        #1;
        chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
        chk("full", 32'(full), 32'(mq.size() == 15));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        qexp(q1, er, ev);
        chk("query_ready1", 32'(query_ready1), 32'(er));
        chk("query_value1", query_value1, ev);
        qexp(q2, er, ev);
        chk("query_ready2", 32'(query_ready2), 32'(er));
        chk("query_value2", query_value2, ev);
        @(posedge clk);
        if (rs || fl) begin
            mq.delete();
            m_tail = 1;
        end else begin
            was_full = (mq.size() == 15);
            if (mq.size() > 0 && mq[0].done) begin
                exp_q.push_back('{rd: mq[0].rd, tag: mq[0].tag,
                                  val: mq[0].val});
                void'(mq.pop_front());
            end
            if (cv && ct != 0)
                foreach (mq[i])
                    if (mq[i].tag == ct) begin
                        mq[i].done = 1;
                        mq[i].val  = cval;
                    end
            if (av && !was_full) begin
                mq.push_back('{tag: 4'(m_tail), rd: rd, done: 0, val: '0});
                m_tail = (m_tail == 15) ? 1 : m_tail + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [3:0] pick_tag();
        if (mq.size() > 0 && $urandom_range(7) != 0)
            return mq[$urandom_range(mq.size() - 1)].tag;
        return 4'($urandom);
    endfunction

    // Monitor: every cycle, compare the commit port with the scoreboard.
    initial begin
        cmt_t e;
        wait (go);
        forever begin
            @(posedge clk);
            #1;
            if (commit_tag !== 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit_tag", 32'(commit_tag), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_tag", 32'(commit_tag), 32'(e.tag));
                    chk("commit_reg", 32'(commit_reg), 32'(e.rd));
                    chk("commit_value", commit_value, e.val);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("missing_commit_tag", 32'(commit_tag), 32'(e.tag));
                end
                chk("idle_commit_reg", 32'(commit_reg), 32'd0);
                chk("idle_commit_value", commit_value, 32'd0);
            end
        end
    end

    initial begin
        bit          av, cv, fl, rs;
        logic [4:0]  rd;
        logic [3:0]  ct, q1, q2;
        int          ap;
        rst = 1; flush = 0; alloc_valid = 0; alloc_rd = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
        query_tag1 = 0; query_tag2 = 0;
        mq.delete();
        m_tail = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("reset_commit_reg", 32'(commit_reg), 32'd0);
        chk("reset_commit_tag", 32'(commit_tag), 32'd0);
        chk("reset_commit_value", commit_value, 32'd0);
        go = 1;

        // basic flow
        step(1, 5, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 32'hDEAD, 1, 0, 0, 0);
        idle(3);

        // out-of-order completion
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 32'h33, 3, 1, 0, 0);
        step(0, 0, 1, 2, 32'h22, 2, 3, 0, 0);
        step(0, 0, 1, 1, 32'h11, 1, 2, 0, 0);
        idle(4);

        // full, refusal, wrap
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++)
            step(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'hA1, 1, 0, 0, 0);
        step(1, 9, 0, 0, 0, 1, 0, 0, 0);
        step(1, 10, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // bypass, then flush with six live entries
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 5'(i + 4), 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4, 32'h1234, 4, 0, 0, 0);
        step(1, 8, 0, 0, 0, 4, 0, 0, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 1, 2, 32'h77, 2, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 6; i++)
            step(1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
        step(1, 7, 1, 1, 32'h55, 1, 0, 0, 1);
        idle(2);

        // rd=0 entry and stray CDB
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 32'hBEEF, 1, 0, 0, 0);
        step(0, 0, 1, 9, 32'h999, 9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 9, 1, 0, 0);
        idle(2);

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            ap = ((c / 200) % 3 == 0) ? 90 : ((c / 200) % 3 == 1) ? 50 : 20;
            av = ($urandom_range(99) < ap);
            rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            cv = ($urandom_range(99) < 55);
            ct = pick_tag();
            q1 = pick_tag();
            q2 = ($urandom_range(3) == 0) ? 4'd0 : pick_tag();
            fl = ($urandom_range(99) == 0);
            rs = ($urandom_range(299) == 0);
            step(av, rd, cv, ct, $urandom, q1, q2, fl, rs);
        end
        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
